nx_fifo_thresh: RTL

Synchronous single-clock FIFO, parametrised in width and depth, for use wherever fixed-size `nx_fifo` instances need non-power-of-2 depths or watermark flags. Head data is first-word-fall-through. The block adds almost-full and almost-empty flags with parameter thresholds, and a write-through-when-full rule. It also provides sticky error status alongside the per-cycle overflow and underflow pulses.

---
 rtl/nx_fifo_pkg.sv | 14 +
 rtl/nx_fifo_thresh_ctrl.sv | 111 +++++++++++
 rtl/nx_fifo_thresh.sv | 86 ++++++++
 3 files changed

// File: rtl/nx_fifo_pkg.sv
// Shared types and helpers for the nx_fifo family: count-width function and
// the sticky error status layout.
package nx_fifo_pkg;

  function automatic int NX_FIFO_CW(input int d);
    return $clog2(d + 1);
  endfunction

  typedef struct packed {
    logic ovf;
    logic unf;
  } nx_fifo_err_t;

endpackage

// File: rtl/nx_fifo_thresh_ctrl.sv
// Control path of nx_fifo_thresh: pointers, occupancy count, flags, error pulses.
// High-water mark tracking is built only when NX_FIFO_HWM_EN is defined.
module nx_fifo_thresh_ctrl
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wen,
  input  logic                          ren,
  input  logic                          clear,
  output logic [$clog2(DEPTH)-1:0]      rptr,
  output logic [$clog2(DEPTH)-1:0]      wptr,
  output logic                          wr_ok,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [NX_FIFO_CW(DEPTH)-1:0]  used_slots,
  output logic [NX_FIFO_CW(DEPTH)-1:0]  free_slots,
  output logic                          overflow,
  output logic                          underflow,
`ifdef NX_FIFO_HWM_EN
  output logic [NX_FIFO_CW(DEPTH)-1:0]  peak_used,
`endif
  output logic [1:0]                    err_sticky
);

  localparam int CW = NX_FIFO_CW(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [PW-1:0] rptr_nxt;
  logic [PW-1:0] wptr_nxt;
  logic          rd_ok;
  logic          ovf_nxt;
  logic          unf_nxt;
  nx_fifo_err_t  err_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign used_slots   = count;
  assign free_slots   = CW'(DEPTH) - count;
  assign almost_full  = (int'(count) >= AFULL_THRESH);
  assign almost_empty = (int'(count) <= AEMPTY_THRESH);
  assign err_sticky   = err_q;

  // A pop in the same cycle frees the slot, so a full FIFO can still take a write.
  always_comb begin
    wr_ok     = wen & (~full | ren) & ~clear;
    rd_ok     = ren & ~empty & ~clear;
    ovf_nxt   = wen & full & ~ren & ~clear;
    unf_nxt   = ren & empty & ~clear;
    rptr_nxt  = rptr;
    wptr_nxt  = wptr;
    count_nxt = count;
    if (clear) begin
      rptr_nxt  = '0;
      wptr_nxt  = '0;
      count_nxt = '0;
    end else begin
      if (rd_ok) rptr_nxt = ptr_inc(rptr);
      if (wr_ok) wptr_nxt = ptr_inc(wptr);
      case ({wr_ok, rd_ok})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      err_q     <= '0;
    end else begin
      rptr      <= rptr_nxt;
      wptr      <= wptr_nxt;
      count     <= count_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
      err_q.ovf <= err_q.ovf | ovf_nxt;
      err_q.unf <= err_q.unf | unf_nxt;
    end
  end

`ifdef NX_FIFO_HWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_used <= '0;
    end else if (clear) begin
      peak_used <= '0;
    end else if (count_nxt > peak_used) begin
      peak_used <= count_nxt;
    end
  end
`endif

endmodule

// File: rtl/nx_fifo_thresh.sv
// First-word-fall-through FIFO with watermark flags and sticky error status.
// Define NX_FIFO_HWM_EN to add the peak_used high-water-mark output.
module nx_fifo_thresh
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int WIDTH         = 32,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter int DATA_RESET    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wen,
  input  logic                          ren,
  input  logic                          clear,
  input  logic [WIDTH-1:0]              wdata,
  output logic [WIDTH-1:0]              rdata,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [NX_FIFO_CW(DEPTH)-1:0]  used_slots,
  output logic [NX_FIFO_CW(DEPTH)-1:0]  free_slots,
  output logic                          overflow,
  output logic                          underflow,
`ifdef NX_FIFO_HWM_EN
  output logic [NX_FIFO_CW(DEPTH)-1:0]  peak_used,
`endif
  output logic [1:0]                    err_sticky
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic             wr_ok;
  logic [WIDTH-1:0] mem [DEPTH];

  nx_fifo_thresh_ctrl #(
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AFULL_THRESH),
    .AEMPTY_THRESH (AEMPTY_THRESH)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .wen          (wen),
    .ren          (ren),
    .clear        (clear),
    .rptr         (rptr),
    .wptr         (wptr),
    .wr_ok        (wr_ok),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .used_slots   (used_slots),
    .free_slots   (free_slots),
    .overflow     (overflow),
    .underflow    (underflow),
`ifdef NX_FIFO_HWM_EN
    .peak_used    (peak_used),
`endif
    .err_sticky   (err_sticky)
  );

  generate
    if (DATA_RESET != 0) begin : g_mem_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
          mem[wptr] <= wdata;
        end
      end
    end else begin : g_mem_norst
      always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= wdata;
      end
    end
  endgenerate

  // Head is forced to zero when empty so stale entries never leak out.
  assign rdata = empty ? '0 : mem[rptr];

endmodule
